// File: rtl/cp_pi_arbiter.sv
// cp_pi_arbiter
//   Shares one 64Kx8 SRAM and the mailbox IRQ flags between two asynchronous
//   requesters: side A (Amiga clock port) and side B (Raspberry Pi). Each side
//   runs a four-phase REQ/ACK handshake and owns a 16-bit auto-incrementing
//   SRAM pointer.
//
//   Per-side registers: 0 = SRAM data at own pointer, 1 = IRQ,
//                       2 = pointer[7:0], 3 = pointer[15:8].
//
//   Ports:
//     CLK, RST_n                       clock, async active-low reset
//     X_REQ, X_WR, X_ADDR, X_WDATA     side X request and access (X = A, B)
//     X_RDATA, X_ACK                   side X read data and acknowledge
//     A_IRQ, B_IRQ                     mailbox interrupts, active high
//     RAM_A, RAM_DO, RAM_DI            SRAM address / write data / read data
//     RAM_OE_n, RAM_WE_n               SRAM strobes, active low
//
//   Build option: define CP_PRIORITY_EN to give side A every tie instead of
//   round-robin arbitration.
//
//   state | meaning
//   IDLE  | waiting for a pending request, arbitrates and latches the access
//   SETUP | asserts the SRAM strobe for register 0 accesses
//   ACCESS| strobe held WE_CYCLES clocks, read data captured on the last edge
//   DONE  | updates the granted side's RDATA/register/pointer, raises ACK

module cp_pi_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int WE_CYCLES   = 1
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        A_REQ,
    input  logic        A_WR,
    input  logic [1:0]  A_ADDR,
    input  logic [7:0]  A_WDATA,
    output logic [7:0]  A_RDATA,
    output logic        A_ACK,
    input  logic        B_REQ,
    input  logic        B_WR,
    input  logic [1:0]  B_ADDR,
    input  logic [7:0]  B_WDATA,
    output logic [7:0]  B_RDATA,
    output logic        B_ACK,
    output logic        A_IRQ,
    output logic        B_IRQ,
    output logic [15:0] RAM_A,
    output logic [7:0]  RAM_DO,
    input  logic [7:0]  RAM_DI,
    output logic        RAM_OE_n,
    output logic        RAM_WE_n
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
    logic                   grant_b_q, last_b_q;
    logic                   wr_q;
    logic [1:0]             addr_q;
    logic [7:0]             wd_q, dcap_q;
    logic [1:0]             cnt_q;
    logic [15:0]            ptr_a_q, ptr_b_q;
    logic [7:0]             a_rdata_q, b_rdata_q;
    logic                   a_ack_q, b_ack_q, a_irq_q, b_irq_q;
    logic [15:0]            ram_a_q;
    logic [7:0]             ram_do_q;
    logic                   oe_n_q, we_n_q;

    logic        a_req_s, b_req_s, a_pend, b_pend, pick_a;
    logic [15:0] own_ptr;
    logic        own_irq, oth_irq;
    logic [7:0]  rd_val;

    assign a_req_s = a_sync_q[SYNC_STAGES-1];
    assign b_req_s = b_sync_q[SYNC_STAGES-1];
    assign a_pend  = a_req_s && !a_ack_q;
    assign b_pend  = b_req_s && !b_ack_q;

`ifdef CP_PRIORITY_EN
    assign pick_a = a_pend;
`else
    // last_grant_q = 1 means B was served last, so A wins the tie
    assign pick_a = a_pend && (!b_pend || last_b_q);
`endif

    always_comb begin
        own_ptr = grant_b_q ? ptr_b_q : ptr_a_q;
        own_irq = grant_b_q ? b_irq_q : a_irq_q;
        oth_irq = grant_b_q ? a_irq_q : b_irq_q;
        case (addr_q)
            2'd0:    rd_val = dcap_q;
            2'd1:    rd_val = {6'b0, oth_irq, own_irq};
            2'd2:    rd_val = own_ptr[7:0];
            default: rd_val = own_ptr[15:8];
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (a_pend || b_pend) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (cnt_q == 2'd0) state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= S_IDLE;
            a_sync_q  <= '0;
            b_sync_q  <= '0;
            grant_b_q <= 1'b0;
            last_b_q  <= 1'b1;
            wr_q      <= 1'b0;
            addr_q    <= 2'd0;
            wd_q      <= 8'd0;
            dcap_q    <= 8'd0;
            cnt_q     <= 2'd0;
            ptr_a_q   <= 16'd0;
            ptr_b_q   <= 16'd0;
            a_rdata_q <= 8'd0;
            b_rdata_q <= 8'd0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_irq_q   <= 1'b0;
            b_irq_q   <= 1'b0;
            ram_a_q   <= 16'd0;
            ram_do_q  <= 8'd0;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], A_REQ};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], B_REQ};

            // ACK follows the synchronised REQ down in any state; a DONE
            // below overrides this for the side being acknowledged.
            if (!a_req_s) a_ack_q <= 1'b0;
            if (!b_req_s) b_ack_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (a_pend || b_pend) begin
                        grant_b_q <= !pick_a;
                        last_b_q  <= !pick_a;
                        wr_q      <= pick_a ? A_WR    : B_WR;
                        addr_q    <= pick_a ? A_ADDR  : B_ADDR;
                        wd_q      <= pick_a ? A_WDATA : B_WDATA;
                        ram_a_q   <= pick_a ? ptr_a_q : ptr_b_q;
                        ram_do_q  <= pick_a ? A_WDATA : B_WDATA;
                    end
                end
                S_SETUP: begin
                    cnt_q <= 2'(WE_CYCLES - 1);
                    if (addr_q == 2'd0) begin
                        if (wr_q) we_n_q <= 1'b0;
                        else      oe_n_q <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    if (cnt_q == 2'd0) begin
                        // strobes are released on the last ACCESS edge so the
                        // low pulse spans exactly WE_CYCLES clocks
                        oe_n_q <= 1'b1;
                        we_n_q <= 1'b1;
                        if (addr_q == 2'd0 && !wr_q) dcap_q <= RAM_DI;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: begin
                    oe_n_q <= 1'b1;
                    we_n_q <= 1'b1;
                    if (wr_q && addr_q == 2'd1) begin
                        if (wd_q[0]) begin
                            if (grant_b_q) a_irq_q <= 1'b1;
                            else           b_irq_q <= 1'b1;
                        end else begin
                            if (grant_b_q) b_irq_q <= 1'b0;
                            else           a_irq_q <= 1'b0;
                        end
                    end
                    if (!grant_b_q) begin
                        if (addr_q == 2'd0)                 ptr_a_q       <= ptr_a_q + 16'd1;
                        else if (wr_q && addr_q == 2'd2)    ptr_a_q[7:0]  <= wd_q;
                        else if (wr_q && addr_q == 2'd3)    ptr_a_q[15:8] <= wd_q;
                        if (!wr_q) a_rdata_q <= rd_val;
                        a_ack_q <= 1'b1;
                    end else begin
                        if (addr_q == 2'd0)                 ptr_b_q       <= ptr_b_q + 16'd1;
                        else if (wr_q && addr_q == 2'd2)    ptr_b_q[7:0]  <= wd_q;
                        else if (wr_q && addr_q == 2'd3)    ptr_b_q[15:8] <= wd_q;
                        if (!wr_q) b_rdata_q <= rd_val;
                        b_ack_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign A_RDATA  = a_rdata_q;
    assign B_RDATA  = b_rdata_q;
    assign A_ACK    = a_ack_q;
    assign B_ACK    = b_ack_q;
    assign A_IRQ    = a_irq_q;
    assign B_IRQ    = b_irq_q;
    assign RAM_A    = ram_a_q;
    assign RAM_DO   = ram_do_q;
    assign RAM_OE_n = oe_n_q;
    assign RAM_WE_n = we_n_q;

endmodule

// File: tb/tb_cp_pi_arbiter.sv
module tb_cp_pi_arbiter;

    localparam int WE  = 1;
    localparam int LAT = 2 + 3 + WE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_req = 0, a_wr = 0, b_req = 0, b_wr = 0;
    logic [1:0]  a_addr = 0, b_addr = 0;
    logic [7:0]  a_wdata = 0, b_wdata = 0, ram_di = 0;
    logic [7:0]  a_rdata, b_rdata;
    logic        a_ack, b_ack, a_irq, b_irq, ram_oe_n, ram_we_n;
    logic [15:0] ram_a;
    logic [7:0]  ram_do;

    int checks = 0;
    int errors = 0;

    // bench-side strobe monitor
    int          we_lo = 0, oe_lo = 0;
    logic [15:0] seen_a = 0;
    logic [7:0]  seen_do = 0;

    always #5 clk = ~clk;

    cp_pi_arbiter #(.SYNC_STAGES(2), .WE_CYCLES(WE)) dut (
        .CLK(clk), .RST_n(rst_n),
        .A_REQ(a_req), .A_WR(a_wr), .A_ADDR(a_addr), .A_WDATA(a_wdata),
        .A_RDATA(a_rdata), .A_ACK(a_ack),
        .B_REQ(b_req), .B_WR(b_wr), .B_ADDR(b_addr), .B_WDATA(b_wdata),
        .B_RDATA(b_rdata), .B_ACK(b_ack),
        .A_IRQ(a_irq), .B_IRQ(b_irq),
        .RAM_A(ram_a), .RAM_DO(ram_do), .RAM_DI(ram_di),
        .RAM_OE_n(ram_oe_n), .RAM_WE_n(ram_we_n)
    );

    always @(negedge clk) begin
        if (!ram_we_n) begin we_lo++; seen_a = ram_a; seen_do = ram_do; end
        if (!ram_oe_n) begin oe_lo++; seen_a = ram_a; end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          side;      // 0 = A, 1 = B
        bit          wr;
        logic [1:0]  addr;
        logic [7:0]  wd;
        logic [7:0]  di;
        logic [7:0]  exp_rd;
        bit          exp_a_irq;
        bit          exp_b_irq;
        int          strobe;    // 0 none, 1 write, 2 read
        logic [15:0] exp_ram_a;
    } vec_t;

    vec_t vecs[21];

    task automatic access(input bit side, input bit wr, input logic [1:0] addr,
                          input logic [7:0] wd, output logic [7:0] rd, output int lat);
        int n;
        @(posedge clk); #1;
        we_lo = 0; oe_lo = 0;
        lat = -1;
        rd = 8'h00;
        if (!side) begin a_wr = wr; a_addr = addr; a_wdata = wd; a_req = 1; end
        else       begin b_wr = wr; b_addr = addr; b_wdata = wd; b_req = 1; end
        for (n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (side ? b_ack : a_ack) begin
                lat = n;
                rd = side ? b_rdata : a_rdata;
                break;
            end
        end
        if (lat < 0) chk("ack_timeout", 0, 1);
        a_req = 0; b_req = 0;
        for (n = 0; n < 20 && (a_ack || b_ack); n++) begin
            @(posedge clk); #1;
        end
        if (a_ack || b_ack) chk("ack_release_timeout", 0, 1);
    endtask

    // both sides request reads of reg2 on the same edge; first_b = expected winner
    task automatic tie(input string name, input bit first_b);
        int n;
        bit got;
        @(posedge clk); #1;
        a_wr = 0; a_addr = 2; b_wr = 0; b_addr = 2;
        a_req = 1; b_req = 1;
        for (n = 0; n < 40 && !a_ack && !b_ack; n++) begin
            @(posedge clk); #1;
        end
        chk({name, "_first_a_ack"}, a_ack, !first_b);
        chk({name, "_first_b_ack"}, b_ack, first_b);
        got = b_ack;
        if (got) b_req = 0; else a_req = 0;
        for (n = 0; n < 40 && !(got ? a_ack : b_ack); n++) begin
            @(posedge clk); #1;
        end
        chk({name, "_second_ack"}, got ? a_ack : b_ack, 1);
        a_req = 0; b_req = 0;
        for (n = 0; n < 20 && (a_ack || b_ack); n++) begin
            @(posedge clk); #1;
        end
        chk({name, "_acks_low"}, {a_ack, b_ack}, 2'b00);
    endtask

    initial begin
        logic [7:0] rd;
        int lat;
        int n;

        vecs[0]  = '{0, 1, 2'd2, 8'h34, 8'h00, 8'h00, 0, 0, 0, 16'h0000};
        vecs[1]  = '{0, 1, 2'd3, 8'h12, 8'h00, 8'h00, 0, 0, 0, 16'h0000};
        vecs[2]  = '{0, 1, 2'd0, 8'hAB, 8'h00, 8'h00, 0, 0, 1, 16'h1234};
        vecs[3]  = '{0, 0, 2'd2, 8'h00, 8'h00, 8'h35, 0, 0, 0, 16'h0000};
        vecs[4]  = '{0, 0, 2'd3, 8'h00, 8'h00, 8'h12, 0, 0, 0, 16'h0000};
        vecs[5]  = '{1, 1, 2'd2, 8'h34, 8'h00, 8'h00, 0, 0, 0, 16'h0000};
        vecs[6]  = '{1, 1, 2'd3, 8'h12, 8'h00, 8'h00, 0, 0, 0, 16'h0000};
        vecs[7]  = '{1, 0, 2'd0, 8'h00, 8'hAB, 8'hAB, 0, 0, 2, 16'h1234};
        vecs[8]  = '{1, 0, 2'd2, 8'h00, 8'h00, 8'h35, 0, 0, 0, 16'h0000};
        vecs[9]  = '{0, 0, 2'd2, 8'h00, 8'h00, 8'h35, 0, 0, 0, 16'h0000};
        vecs[10] = '{0, 1, 2'd1, 8'h01, 8'h00, 8'h00, 0, 1, 0, 16'h0000};
        vecs[11] = '{1, 0, 2'd1, 8'h00, 8'h00, 8'h01, 0, 1, 0, 16'h0000};
        vecs[12] = '{0, 0, 2'd1, 8'h00, 8'h00, 8'h02, 0, 1, 0, 16'h0000};
        vecs[13] = '{1, 1, 2'd1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 16'h0000};
        vecs[14] = '{1, 0, 2'd1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 16'h0000};
        vecs[15] = '{0, 1, 2'd2, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 16'h0000};
        vecs[16] = '{0, 1, 2'd3, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 16'h0000};
        vecs[17] = '{0, 0, 2'd0, 8'h00, 8'h5A, 8'h5A, 0, 0, 2, 16'hFFFF};
        vecs[18] = '{0, 0, 2'd2, 8'h00, 8'h00, 8'h00, 0, 0, 0, 16'h0000};
        vecs[19] = '{0, 0, 2'd3, 8'h00, 8'h00, 8'h00, 0, 0, 0, 16'h0000};
        vecs[20] = '{1, 0, 2'd2, 8'h00, 8'h00, 8'h35, 0, 0, 0, 16'h0000};

        // reset state
        #3 rst_n = 0;
        #2;
        chk("rst_a_ack", a_ack, 0);
        chk("rst_b_ack", b_ack, 0);
        chk("rst_rdata", {a_rdata, b_rdata}, 16'h0000);
        chk("rst_irq", {a_irq, b_irq}, 2'b00);
        chk("rst_ram_a", ram_a, 16'h0000);
        chk("rst_ram_do", ram_do, 8'h00);
        chk("rst_strobes", {ram_oe_n, ram_we_n}, 2'b11);
        repeat (3) @(posedge clk);
        #2 rst_n = 1;

        foreach (vecs[i]) begin
            ram_di = vecs[i].di;
            access(vecs[i].side, vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, lat);
            chk($sformatf("v%0d_latency", i), lat, LAT);
            if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_a_irq", i), a_irq, vecs[i].exp_a_irq);
            chk($sformatf("v%0d_b_irq", i), b_irq, vecs[i].exp_b_irq);
            chk($sformatf("v%0d_we_clocks", i), we_lo, (vecs[i].strobe == 1) ? WE : 0);
            chk($sformatf("v%0d_oe_clocks", i), oe_lo, (vecs[i].strobe == 2) ? WE : 0);
            if (vecs[i].strobe != 0) chk($sformatf("v%0d_ram_a", i), seen_a, vecs[i].exp_ram_a);
            if (vecs[i].strobe == 1) chk($sformatf("v%0d_ram_do", i), seen_do, vecs[i].wd);
        end

        // ties: A,B then A,B; after a lone A access the next tie shows the policy
        tie("tie1", 0);
        tie("tie2", 0);
        access(0, 0, 2'd2, 8'h00, rd, lat);
`ifdef CP_PRIORITY_EN
        tie("tie3", 0);
`else
        tie("tie3", 1);
`endif

        // reset while an SRAM write is in ACCESS
        access(0, 1, 2'd2, 8'h10, rd, lat);
        access(1, 1, 2'd3, 8'h22, rd, lat);
        @(posedge clk); #1;
        a_wr = 1; a_addr = 0; a_wdata = 8'h77; a_req = 1;
        for (n = 0; n < 40 && ram_we_n; n++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_we_seen", ram_we_n, 0);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_we_release", ram_we_n, 1);
        chk("rst_mid_oe", ram_oe_n, 1);
        chk("rst_mid_ack", a_ack, 0);
        a_req = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_ack_held", a_ack, 0);
        rst_n = 1;
        access(0, 0, 2'd2, 8'h00, rd, lat);
        chk("post_rst_a_ptr_lo", rd, 8'h00);
        access(0, 0, 2'd3, 8'h00, rd, lat);
        chk("post_rst_a_ptr_hi", rd, 8'h00);
        access(1, 0, 2'd3, 8'h00, rd, lat);
        chk("post_rst_b_ptr_hi", rd, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/cp_pi_arbiter.md
Name: cp_pi_arbiter

Overview:
- Sequences and shares the board's single 64Kx8 SRAM and the mailbox IRQ flags between two asynchronous requesters: side A (Amiga clock port) and side B (Raspberry Pi).
- Each side runs a four-phase REQ/ACK handshake with its own 16-bit auto-incrementing address pointer, so a side switch needs no address swap cycle.
- Sits between the bus-facing glue (latch/OE control, open-drain INT6 driver) and the SRAM pins.

Parameters:
SYNC_STAGES, 2, flops in each REQ synchroniser (min 2)
WE_CYCLES, 1, clocks RAM_WE_n is held low on an SRAM write (1..4)

Ports:
CLK  in  1  system clock (~100 MHz)
RST_n  in  1  asynchronous active-low reset
A_REQ  in  1  side A request, asynchronous
A_WR  in  1  side A write (1) / read (0); stable while A_REQ high
A_ADDR  in  2  side A register select; stable while A_REQ high
A_WDATA  in  8  side A write data; stable while A_REQ high
A_RDATA  out  8  side A read data; valid while A_ACK high
A_ACK  out  1  side A acknowledge
B_REQ, B_WR, B_ADDR, B_WDATA, B_RDATA, B_ACK: same as side A, for side B
A_IRQ  out  1  interrupt to side A, active high
B_IRQ  out  1  interrupt to side B, active high
RAM_A  out  16  SRAM address
RAM_DO  out  8  SRAM write data
RAM_DI  in  8  SRAM read data
RAM_OE_n  out  1  SRAM output enable
RAM_WE_n  out  1  SRAM write enable

Behaviour:
- Registers per side: 0 = SRAM data at own pointer; 1 = IRQ; 2 = pointer[7:0]; 3 = pointer[15:8].
- Reset (async, immediate): RAM_OE_n = RAM_WE_n = 1, all ACKs 0, RDATA 0, IRQs 0, both pointers 0, RAM_A 0, RAM_DO 0, state IDLE, last_grant = B (A wins the first tie). Reset mid-access aborts it and releases the strobes at once; the aborted access has no effect.
- Pending(X) = X_REQ_sync && !X_ACK. X_ACK clears on the first clock with X_REQ_sync low, in any state.
- IDLE:
  - If one side is pending, grant it.
  - If both are pending, grant the side that is not last_grant (round-robin). Update last_grant.
  - On grant: latch WR, ADDR and WDATA; load RAM_A from the granted pointer; RAM_DO = WDATA. Go to SETUP.
- SETUP:
  - SRAM read: RAM_OE_n = 0.
  - SRAM write: RAM_WE_n = 0 and hold for WE_CYCLES clocks in ACCESS.
  - Non-SRAM register: no strobe.
  - Go to ACCESS.
- ACCESS: lasts WE_CYCLES clocks; for an SRAM read, RAM_DI is captured on the last edge. Go to DONE.
- DONE:
  - RAM_OE_n = RAM_WE_n = 1.
  - Update the granted side's RDATA or register.
  - For register 0, increment the granted pointer mod 2^16 (FFFF wraps to 0000).
  - Set ACK. Return to IDLE.
- Latency: ACK rises SYNC_STAGES+3+WE_CYCLES edges after the first edge that samples REQ high (6 with defaults). The next grant can occur at the earliest on the edge after DONE.
- IRQ register:
  - Write bit0 = 1: raise the other side's IRQ.
  - Write bit0 = 0: clear own IRQ.
  - Read returns {6'b0, other side's IRQ, own IRQ}.
  - Same-edge raise and clear cannot occur because accesses are serialised.
- Pointer registers: a write replaces the byte; a read returns the current byte. Pointer writes and reads never touch the SRAM.
- Both pointers are independent. A side's pointer changes only through its own accesses.
- A REQ dropped before ACK is a protocol violation; the granted access still completes. ACK then clears once REQ_sync is low.

Optional Feature:
- Macro: CP_PRIORITY_EN.
- Defined: side A wins every tie, because Amiga bus cycles have hard timing; last_grant is ignored.
- Undefined: round-robin as above.
- All other behaviour is identical.

Test Plan:
- A writes reg2=0x34, reg3=0x12, then reg0=0xAB: one RAM_WE_n low pulse of WE_CYCLES clocks at RAM_A=0x1234 with RAM_DO=0xAB; A pointer becomes 0x1235; A_ACK rises 6 edges after A_REQ.
- B sets pointer to 0x1234 and reads reg0 with RAM_DI=0xAB: RAM_OE_n low, B_RDATA=0xAB while B_ACK is high; B pointer becomes 0x1235; A pointer is unchanged.
- A_REQ and B_REQ rise on the same edge, twice in a row: grants go A then B, then A then B; with CP_PRIORITY_EN defined, A wins both ties.
- A pointer is 0xFFFF and A reads reg0: RAM_A=0xFFFF, then the A pointer wraps to 0x0000.
- A writes reg1=0x01: B_IRQ=1; B reads reg1 and gets 0x01; B writes reg1=0x00: B_IRQ=0; A_IRQ stays 0 throughout.
- RST_n asserted during ACCESS of an SRAM write: RAM_WE_n goes high asynchronously; no ACK; pointers are 0 after release.
